// File: rtl/execution_block_p_if.sv
// Operand/opcode handshake and result bundle between decode, the execution
// stage, writeback, data memory and the output port.
interface execution_block_p_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] data_in;
    logic [4:0]       op_dec;
    logic             op_valid;
    logic             ready;
    logic             ans_valid;
    logic [WIDTH-1:0] ans_ex;
    logic [3:0]       flag_ex;
    logic [WIDTH-1:0] DM_data;
    logic [WIDTH-1:0] data_out;

    modport master (
        output A, B, data_in, op_dec, op_valid,
        input  ready, ans_valid, ans_ex, flag_ex, DM_data, data_out
    );

    modport slave (
        input  A, B, data_in, op_dec, op_valid,
        output ready, ans_valid, ans_ex, flag_ex, DM_data, data_out
    );
endinterface

// File: rtl/execution_block_p.sv
// Execution stage: single-cycle ALU/shift/I-O/store ops and a shift-add
// multiplier behind a valid/ready handshake, with a persistent {Z,C,S,V} register.
module execution_block_p #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    execution_block_p_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADC  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SBB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_INC  = 5'b01000;
    localparam logic [4:0] OP_DEC  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01010;
    localparam logic [4:0] OP_SHR  = 5'b01011;
    localparam logic [4:0] OP_ROL  = 5'b01100;
    localparam logic [4:0] OP_ROR  = 5'b01101;
    localparam logic [4:0] OP_ASR  = 5'b01110;
    localparam logic [4:0] OP_CMP  = 5'b01111;
    localparam logic [4:0] OP_MOV  = 5'b10000;
    localparam logic [4:0] OP_IN   = 5'b10001;
    localparam logic [4:0] OP_OUT  = 5'b10010;
    localparam logic [4:0] OP_STO  = 5'b10011;
    localparam logic [4:0] OP_MUL  = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b10101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     ans_r;
    logic [3:0]           flag_r;
    logic [WIDTH-1:0]     dm_r;
    logic [WIDTH-1:0]     dout_r;
    logic [WIDTH-1:0]     hi_r;
    logic                 valid_r;
    logic                 ready_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [CW-1:0]        cnt_r;

    logic                 accept_s;
    logic                 c_in_s;
    logic [WIDTH:0]       wide_s;
    logic [WIDTH-1:0]     res_s;
    logic                 c_s;
    logic                 v_s;
    logic [3:0]           flag_s;
    logic                 wr_ans_s;
    logic                 wr_flag_s;
    logic                 wr_out_s;
    logic                 wr_dm_s;
    logic                 mul_start_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic                 hi_nz_s;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign accept_s = bus.op_valid & ready_r;
    assign c_in_s   = flag_r[2];

    // Single-cycle result, flag update and write enables for the current opcode.
    always_comb begin
        wide_s      = {(WIDTH+1){1'b0}};
        res_s       = ans_r;
        c_s         = c_in_s;
        v_s         = 1'b0;
        wr_ans_s    = 1'b0;
        wr_flag_s   = 1'b0;
        wr_out_s    = 1'b0;
        wr_dm_s     = 1'b0;
        mul_start_s = 1'b0;
        case (bus.op_dec)
            OP_ADD, OP_ADC: begin
                wide_s    = {1'b0, bus.A} + {1'b0, bus.B}
                          + {{WIDTH{1'b0}}, (bus.op_dec == OP_ADC) & c_in_s};
                res_s     = wide_s[WIDTH-1:0];
                c_s       = wide_s[WIDTH];
                v_s       = add_ovf(bus.A, bus.B, wide_s[WIDTH-1:0]);
                wr_ans_s  = 1'b1;
                wr_flag_s = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                // Top bit of the widened difference is the borrow.
                wide_s    = {1'b0, bus.A} - {1'b0, bus.B}
                          - {{WIDTH{1'b0}}, (bus.op_dec == OP_SBB) & c_in_s};
                res_s     = wide_s[WIDTH-1:0];
                c_s       = wide_s[WIDTH];
                v_s       = sub_ovf(bus.A, bus.B, wide_s[WIDTH-1:0]);
                wr_ans_s  = (bus.op_dec != OP_CMP);
                wr_flag_s = 1'b1;
            end
            OP_AND: begin res_s = bus.A & bus.B; c_s = 1'b0; wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_OR:  begin res_s = bus.A | bus.B; c_s = 1'b0; wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_XOR: begin res_s = bus.A ^ bus.B; c_s = 1'b0; wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_NOT: begin res_s = ~bus.A;        c_s = 1'b0; wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_INC: begin
                res_s     = bus.A + ONE;
                v_s       = add_ovf(bus.A, ONE, bus.A + ONE);
                wr_ans_s  = 1'b1;
                wr_flag_s = 1'b1;
            end
            OP_DEC: begin
                res_s     = bus.A - ONE;
                v_s       = sub_ovf(bus.A, ONE, bus.A - ONE);
                wr_ans_s  = 1'b1;
                wr_flag_s = 1'b1;
            end
            OP_SHL: begin res_s = {bus.A[WIDTH-2:0], 1'b0};         c_s = bus.A[WIDTH-1]; wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_SHR: begin res_s = {1'b0, bus.A[WIDTH-1:1]};         c_s = bus.A[0];       wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_ROL: begin res_s = {bus.A[WIDTH-2:0], c_in_s};       c_s = bus.A[WIDTH-1]; wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_ROR: begin res_s = {c_in_s, bus.A[WIDTH-1:1]};       c_s = bus.A[0];       wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_ASR: begin res_s = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]}; c_s = bus.A[0];     wr_ans_s = 1'b1; wr_flag_s = 1'b1; end
            OP_MOV:  begin res_s = bus.B;       wr_ans_s = 1'b1; end
            OP_IN:   begin res_s = bus.data_in; wr_ans_s = 1'b1; end
            OP_OUT:  wr_out_s    = 1'b1;
            OP_STO:  wr_dm_s     = 1'b1;
            OP_MUL:  mul_start_s = 1'b1;
            OP_MFHI: begin res_s = hi_r; wr_ans_s = 1'b1; end
            default: wr_ans_s = 1'b0;
        endcase
        flag_s = {res_s == {WIDTH{1'b0}}, c_s, res_s[WIDTH-1], v_s};
    end

    // One shift-add iteration: conditionally add the multiplicand to the high half, then shift right.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        hi_nz_s    = |acc_r[2*WIDTH-1:WIDTH];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && mul_start_s) begin
                    state_next_s = ST_MUL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Result, flag, port, hi and multiplier datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_r   <= {WIDTH{1'b0}};
            flag_r  <= 4'b0000;
            dm_r    <= {WIDTH{1'b0}};
            dout_r  <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            acc_r   <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            valid_r <= 1'b0;
            if (state_r == ST_DONE) begin
                ans_r   <= acc_r[WIDTH-1:0];
                hi_r    <= acc_r[2*WIDTH-1:WIDTH];
                flag_r  <= {acc_r == {(2*WIDTH){1'b0}}, hi_nz_s, acc_r[WIDTH-1], hi_nz_s};
                valid_r <= 1'b1;
                ready_r <= 1'b1;
            end else if (state_r == ST_MUL) begin
                acc_r <= mul_next_s;
                cnt_r <= cnt_r - CW'(1);
            end else if (accept_s) begin
                if (mul_start_s) begin
                    ready_r <= 1'b0;
                    acc_r   <= {{WIDTH{1'b0}}, bus.B};
                    mcand_r <= bus.A;
                    cnt_r   <= CW'(WIDTH - 1);
                end else begin
                    valid_r <= 1'b1;
                    if (wr_ans_s)  ans_r  <= res_s;
                    if (wr_flag_s) flag_r <= flag_s;
                    if (wr_out_s)  dout_r <= bus.A;
                    if (wr_dm_s)   dm_r   <= bus.A;
                end
            end
        end
    end

    assign bus.ready     = ready_r;
    assign bus.ans_valid = valid_r;
    assign bus.ans_ex    = ans_r;
    assign bus.flag_ex   = flag_r;
    assign bus.DM_data   = dm_r;
    assign bus.data_out  = dout_r;

endmodule

// File: tb/tb_execution_block_p.sv
// Bench for execution_block_p: directed vector table, multiplier/reset corner
// sequences and random ops against an arithmetic reference model.
module tb_execution_block_p;
    localparam int W = 8;
    localparam logic [4:0] OP_MUL  = 5'd20;
    localparam logic [4:0] OP_MFHI = 5'd21;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_ans, m_dout, m_dm, m_hi;
    logic [3:0] m_flag;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] din;
        logic [7:0] ans;
        logic [3:0] flag;
    } vec_t;

    vec_t tbl [27];

    execution_block_p_if #(.WIDTH(W)) bus ();
    execution_block_p #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ans = 8'h00; m_flag = 4'h0; m_dout = 8'h00; m_dm = 8'h00; m_hi = 8'h00;
    endtask

    function automatic bit out_of_range(input int x);
        return (x > 127) || (x < -128);
    endfunction

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic model_apply(input logic [4:0] op, input logic [7:0] a8,
                               input logic [7:0] b8, input logic [7:0] din8);
        int a, b, sa, sb, ci, r, r8, full;
        bit cc, vv, upd_a, upd_f;
        a = int'(a8); b = int'(b8);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        ci = int'(m_flag[2]);
        r = 0; cc = 1'b0; vv = 1'b0; upd_a = 1'b1; upd_f = 1'b1;
        case (op)
            5'd0, 5'd1: begin
                full = a + b + ((op == 5'd1) ? ci : 0);
                r = full; cc = (full > 255);
                vv = out_of_range(sa + sb + ((op == 5'd1) ? ci : 0));
            end
            5'd2, 5'd3, 5'd15: begin
                full = a - b - ((op == 5'd3) ? ci : 0);
                r = full; cc = (full < 0);
                vv = out_of_range(sa - sb - ((op == 5'd3) ? ci : 0));
                upd_a = (op != 5'd15);
            end
            5'd4:  r = a & b;
            5'd5:  r = a | b;
            5'd6:  r = a ^ b;
            5'd7:  r = 255 - a;
            5'd8:  begin r = a + 1; cc = ci[0]; vv = out_of_range(sa + 1); end
            5'd9:  begin r = a - 1; cc = ci[0]; vv = out_of_range(sa - 1); end
            5'd10: begin r = a * 2;            cc = (a >= 128); end
            5'd11: begin r = a / 2;            cc = (a % 2 == 1); end
            5'd12: begin r = a * 2 + ci;       cc = (a >= 128); end
            5'd13: begin r = a / 2 + ci * 128; cc = (a % 2 == 1); end
            5'd14: begin r = a / 2 + ((a >= 128) ? 128 : 0); cc = (a % 2 == 1); end
            5'd16: begin r = b;           upd_f = 1'b0; end
            5'd17: begin r = int'(din8);  upd_f = 1'b0; end
            5'd18: begin m_dout = a8; upd_a = 1'b0; upd_f = 1'b0; end
            5'd19: begin m_dm   = a8; upd_a = 1'b0; upd_f = 1'b0; end
            5'd20: begin
                full = a * b;
                m_ans = 8'(full % 256);
                m_hi  = 8'(full / 256);
                m_flag = {full == 0, full >= 256, (full % 256) >= 128, full >= 256};
                upd_a = 1'b0; upd_f = 1'b0;
            end
            5'd21: begin r = int'(m_hi); upd_f = 1'b0; end
            default: begin upd_a = 1'b0; upd_f = 1'b0; end
        endcase
        r8 = ((r % 256) + 256) % 256;
        if (upd_a) m_ans = r8[7:0];
        if (upd_f) m_flag = {r8 == 0, cc, r8 >= 128, vv};
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_valid"}, bus.ans_valid, 1);
        chk({nm, "_ready"}, bus.ready, 1);
        chk({nm, "_ans"}, bus.ans_ex, m_ans);
        chk({nm, "_flag"}, bus.flag_ex, m_flag);
        chk({nm, "_dout"}, bus.data_out, m_dout);
        chk({nm, "_dm"}, bus.DM_data, m_dm);
    endtask

    // Called at a negedge with ready=1; returns at the negedge where the result is visible.
    task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] din, input bit junk, input string nm);
        int busy;
        bus.op_dec = op; bus.A = a; bus.B = b; bus.data_in = din; bus.op_valid = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        if (op == OP_MUL) begin
            busy = 0;
            while (bus.ans_valid !== 1'b1 && busy < 20) begin
                chk({nm, "_ready_low"}, bus.ready, 0);
                busy++;
                bus.A = 8'($urandom); bus.B = 8'($urandom);
                bus.op_dec = 5'($urandom); bus.op_valid = junk;
                @(negedge clk);
            end
            bus.op_valid = 1'b0;
            chk({nm, "_busy_cycles"}, busy, W + 1);
        end
        model_apply(op, a, b, din);
        chk_model(nm);
    endtask

    initial begin
        tbl[0]  = '{5'd0,  8'h40, 8'hC0, 8'h00, 8'h00, 4'b1100};
        tbl[1]  = '{5'd1,  8'h01, 8'h01, 8'h00, 8'h03, 4'b0000};
        tbl[2]  = '{5'd2,  8'h40, 8'hC0, 8'h00, 8'h80, 4'b0111};
        tbl[3]  = '{5'd15, 8'h05, 8'h05, 8'h00, 8'h80, 4'b1000};
        tbl[4]  = '{5'd12, 8'h80, 8'h00, 8'h00, 8'h00, 4'b1100};
        tbl[5]  = '{5'd13, 8'h00, 8'h00, 8'h00, 8'h80, 4'b0010};
        tbl[6]  = '{5'd3,  8'h10, 8'h05, 8'h00, 8'h0B, 4'b0000};
        tbl[7]  = '{5'd10, 8'hC1, 8'h00, 8'h00, 8'h82, 4'b0110};
        tbl[8]  = '{5'd1,  8'h01, 8'h01, 8'h00, 8'h03, 4'b0000};
        tbl[9]  = '{5'd8,  8'h7F, 8'h00, 8'h00, 8'h80, 4'b0011};
        tbl[10] = '{5'd9,  8'h80, 8'h00, 8'h00, 8'h7F, 4'b0001};
        tbl[11] = '{5'd14, 8'h81, 8'h00, 8'h00, 8'hC0, 4'b0110};
        tbl[12] = '{5'd11, 8'h81, 8'h00, 8'h00, 8'h40, 4'b0100};
        tbl[13] = '{5'd6,  8'hF0, 8'hFF, 8'h00, 8'h0F, 4'b0000};
        tbl[14] = '{5'd7,  8'hFF, 8'h00, 8'h00, 8'h00, 4'b1000};
        tbl[15] = '{5'd16, 8'h00, 8'h3C, 8'h00, 8'h3C, 4'b1000};
        tbl[16] = '{5'd17, 8'h00, 8'h00, 8'h99, 8'h99, 4'b1000};
        tbl[17] = '{5'd18, 8'h5A, 8'h00, 8'h00, 8'h99, 4'b1000};
        tbl[18] = '{5'd19, 8'hA5, 8'h00, 8'h00, 8'h99, 4'b1000};
        tbl[19] = '{5'd22, 8'h11, 8'h22, 8'h33, 8'h99, 4'b1000};
        tbl[20] = '{5'd4,  8'hF0, 8'h3C, 8'h00, 8'h30, 4'b0000};
        tbl[21] = '{5'd5,  8'h0F, 8'hF0, 8'h00, 8'hFF, 4'b0010};
        tbl[22] = '{5'd3,  8'h00, 8'hFF, 8'h00, 8'h01, 4'b0100};
        tbl[23] = '{5'd3,  8'h00, 8'h00, 8'h00, 8'hFF, 4'b0110};
        tbl[24] = '{5'd8,  8'hFF, 8'h00, 8'h00, 8'h00, 4'b1100};
        tbl[25] = '{5'd9,  8'h00, 8'h00, 8'h00, 8'hFF, 4'b0110};
        tbl[26] = '{5'd21, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0110};

        reset = 1'b0;
        bus.A = 8'h00; bus.B = 8'h00; bus.data_in = 8'h00;
        bus.op_dec = 5'd0; bus.op_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ans", bus.ans_ex, 0);
        chk("rst_flag", bus.flag_ex, 0);
        chk("rst_valid", bus.ans_valid, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_dm", bus.DM_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back directed vectors; carry dependencies flow between rows.
        for (int i = 0; i < 27; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].din, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_exp_ans", i), bus.ans_ex, tbl[i].ans);
            chk($sformatf("tbl%0d_exp_flag", i), bus.flag_ex, tbl[i].flag);
        end
        chk("out_latch", bus.data_out, 8'h5A);
        chk("store_latch", bus.DM_data, 8'hA5);
        @(negedge clk);
        chk("idle_no_valid", bus.ans_valid, 0);

        // Full-scale multiply with ignored requests during the busy window.
        run_op(OP_MUL, 8'hFF, 8'hFF, 8'h00, 1'b1, "mul_ff");
        chk("mul_ff_ans", bus.ans_ex, 8'h01);
        chk("mul_ff_flag", bus.flag_ex, 4'b0101);
        run_op(OP_MFHI, 8'h00, 8'h00, 8'h00, 1'b0, "mfhi");
        chk("mfhi_ans", bus.ans_ex, 8'hFE);

        // Reset asserted during the 4th busy cycle aborts the multiply.
        bus.op_dec = OP_MUL; bus.A = 8'hC0; bus.B = 8'h01; bus.op_valid = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ans", bus.ans_ex, 0);
        chk("abort_flag", bus.flag_ex, 0);
        chk("abort_dout", bus.data_out, 0);
        chk("abort_dm", bus.DM_data, 0);
        chk("abort_ready", bus.ready, 1);
        chk("abort_valid", bus.ans_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", bus.ans_valid, 0);
        end
        run_op(OP_MFHI, 8'h00, 8'h00, 8'h00, 1'b0, "abort_hi");
        chk("abort_hi_zero", bus.ans_ex, 8'h00);
        run_op(OP_MUL, 8'hC0, 8'h01, 8'h00, 1'b0, "mul_c0");
        chk("mul_c0_ans", bus.ans_ex, 8'hC0);
        chk("mul_c0_flag", bus.flag_ex, 4'b0010);

        // Random ops against the reference model.
        for (int i = 0; i < 300; i++) begin
            run_op(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), "rnd");
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rnd_idle_no_valid", bus.ans_valid, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
